// File: rtl/test_i6294.sv
// test_i6294: registered 4-input logic function with an optional
// hold-pattern trigger that inverts the output once armed.
//
// Ports:
//   N0..N3 : data inputs, word W = {N0,N1,N2,N3} (N0 is the MSB)
//   CK     : clock, all state updates on the rising edge
//   reset  : synchronous, active-high reset
//   Q      : registered result, Q <= f(W) ^ trig, one cycle of latency
//
// Parameter:
//   TRIG_COUNT : consecutive W==4'b1111 samples that arm the trigger (1..15)
//
// Build option:
//   TEST_I6294_TROJAN_EN : when defined, the hold counter and sticky trigger
//                          are compiled in; when undefined, Q <= f(W).
module test_i6294 #(
    parameter int unsigned TRIG_COUNT = 4
) (
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic CK,
    input  logic reset,
    output logic Q
);

    // Base function of the sampled inputs
    logic w_f;
    assign w_f = (N0 & N1) | (N2 ^ N3);

    logic r_q;

`ifdef TEST_I6294_TROJAN_EN
    localparam int unsigned CNT_W = $clog2(TRIG_COUNT + 1);

    logic [3:0]       w_word;
    logic             w_all_ones;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trig;

    assign w_word     = {N0, N1, N2, N3};
    assign w_all_ones = (w_word == 4'b1111);

    // Output register plus hold counter; once armed the counter freezes at
    // TRIG_COUNT and the trigger stays set until reset.
    always_ff @(posedge CK) begin
        if (reset) begin
            r_q    <= 1'b0;
            r_cnt  <= '0;
            r_trig <= 1'b0;
        end else begin
            // Uses the pre-edge trigger, so the arming edge still yields f
            r_q <= w_f ^ r_trig;
            if (!r_trig) begin
                if (w_all_ones) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(TRIG_COUNT - 1)) begin
                        r_trig <= 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end
`else
    // Output register only
    always_ff @(posedge CK) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_f;
        end
    end
`endif

    assign Q = r_q;

endmodule

// File: tb/tb_test_i6294.sv
// Self-checking bench for test_i6294: reset, truth-table sweep, and the
// hold-pattern sequences (expectations depend on TEST_I6294_TROJAN_EN).
module tb_test_i6294;

    logic N0, N1, N2, N3;
    logic CK;
    logic reset;
    logic Q;

    int total = 0;
    int bad   = 0;

    test_i6294 #(.TRIG_COUNT(4)) dut (
        .N0   (N0),
        .N1   (N1),
        .N2   (N2),
        .N3   (N3),
        .CK   (CK),
        .reset(reset),
        .Q    (Q)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic [3:0] w;
        logic       rst;
        logic       exp_q;
    } vec_t;

    vec_t tbl [18];

    // Drive inputs away from the edge, clock once, check #1 after the edge
    task automatic apply(input logic [3:0] w, input logic rst,
                         input logic exp_q, input string name);
        @(negedge CK);
        {N0, N1, N2, N3} = w;
        reset = rst;
        @(posedge CK);
        #1;
        total++;
        if (Q !== exp_q) begin
            bad++;
            $display("FAIL %s: W=%b reset=%b Q=%b expected=%b",
                     name, w, rst, Q, exp_q);
        end
    endtask

    initial begin
        logic [15:0] sweep_exp;
        sweep_exp = 16'b1111_0110_0110_0110; // bit i = f(W=i)

        {N0, N1, N2, N3} = 4'b0000;
        reset = 1'b1;

        tbl[0] = '{w: 4'b0000, rst: 1'b1, exp_q: 1'b0};
        tbl[1] = '{w: 4'b0000, rst: 1'b0, exp_q: 1'b0};
        for (int i = 0; i < 16; i++) begin
            tbl[i + 2] = '{w: 4'(i), rst: 1'b0, exp_q: sweep_exp[i]};
        end

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].w, tbl[i].rst, tbl[i].exp_q, $sformatf("table[%0d]", i));
        end

        // Reset in the middle of activity clears Q
        apply(4'b0001, 1'b1, 1'b0, "mid_reset");
        apply(4'b0001, 1'b0, 1'b1, "after_mid_reset");

`ifdef TEST_I6294_TROJAN_EN
        // Arm after four 1111 samples; inversion starts on the next edge
        apply(4'b0000, 1'b1, 1'b0, "arm_reset");
        for (int i = 0; i < 4; i++) apply(4'b1111, 1'b0, 1'b1, $sformatf("arm_hold%0d", i));
        apply(4'b0001, 1'b0, 1'b0, "armed_0001");
        apply(4'b0000, 1'b0, 1'b1, "armed_0000");
        apply(4'b1111, 1'b0, 1'b0, "armed_1111");

        // Reset disarms
        apply(4'b0001, 1'b1, 1'b0, "disarm_reset");
        apply(4'b0001, 1'b0, 1'b1, "disarmed_0001");

        // Interrupted run never arms
        for (int i = 0; i < 3; i++) apply(4'b1111, 1'b0, 1'b1, $sformatf("run_a%0d", i));
        apply(4'b0000, 1'b0, 1'b0, "run_break");
        for (int i = 0; i < 3; i++) apply(4'b1111, 1'b0, 1'b1, $sformatf("run_b%0d", i));
        apply(4'b0001, 1'b0, 1'b1, "run_not_armed");

        // Reset wins over an arming edge
        apply(4'b0000, 1'b1, 1'b0, "prio_reset0");
        for (int i = 0; i < 3; i++) apply(4'b1111, 1'b0, 1'b1, $sformatf("prio_hold%0d", i));
        apply(4'b1111, 1'b1, 1'b0, "prio_reset_on_arm");
        apply(4'b0001, 1'b0, 1'b1, "prio_not_armed");
`else
        // No trigger: long 1111 hold never inverts the output
        apply(4'b0000, 1'b1, 1'b0, "hold_reset");
        for (int i = 0; i < 10; i++) apply(4'b1111, 1'b0, 1'b1, $sformatf("hold%0d", i));
        apply(4'b0001, 1'b0, 1'b1, "hold_0001");
        apply(4'b0000, 1'b0, 1'b0, "hold_0000");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/test_i6294.md
TEST_I6294 -- requirements
Module: test_i6294

Interface
REQ-001 Parameter TRIG_COUNT, default 4: number of consecutive sampled 4'b1111 input words that arms the payload; legal range 1..15.
REQ-002 Port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port N0, input, 1 bit: data input bit 0, the MSB of input word W = {N0,N1,N2,N3}.
REQ-005 Port N1, input, 1 bit: data input bit 1.
REQ-006 Port N2, input, 1 bit: data input bit 2.
REQ-007 Port N3, input, 1 bit: data input bit 3, the LSB of W.
REQ-008 Port Q, output, 1 bit: registered result.
REQ-009 Positional port order shall be N0, N1, N2, N3, CK, reset, Q.

Function
REQ-010 Base function: f = (N0 AND N1) OR (N2 XOR N3), evaluated on the inputs sampled at the rising edge of CK.
REQ-011 Q shall be registered with 1-cycle latency: at each non-reset rising edge, Q <= f XOR trig, where trig is the pre-edge value of the trigger flag.
REQ-012 Q shall have no combinational path from any input.
REQ-013 Hold counter cnt, width ceil(log2(TRIG_COUNT+1)): at each non-reset edge with trig=0, cnt <= cnt+1 if W==4'b1111, otherwise cnt <= 0.
REQ-014 Trigger flag trig: set at the edge where W==4'b1111 and cnt==TRIG_COUNT-1, with trig=0 before that edge.
REQ-015 The output inversion shall first appear at the next edge after trig is set: Q on the arming edge still equals f.
REQ-016 Once set, trig shall be sticky until reset, and cnt shall freeze at TRIG_COUNT.
REQ-017 Any W other than 4'b1111 before arming shall clear cnt to 0; W values after arming shall not affect trig.
REQ-018 No other internal state is permitted; the output is fully determined by W history, reset and the configuration macro.

Reset
REQ-019 When reset=1 at a rising edge: Q <= 0, cnt <= 0, trig <= 0.
REQ-020 Reset shall take priority over all other updates on the same edge, including an arming edge.
REQ-021 Reset asserted mid-count or after arming shall fully clear state; counting restarts from 0 at the first non-reset edge.
REQ-022 Between power-up and the first reset edge, Q is undefined; the bench shall apply reset first.

Configuration
REQ-023 Macro TEST_I6294_TROJAN_EN defined: the cnt/trig logic of REQ-013..REQ-017 is compiled in.
REQ-024 Macro TEST_I6294_TROJAN_EN undefined: cnt and trig do not exist, trig is constant 0, and Q <= f at every non-reset edge.
REQ-025 For any input sequence that never holds W==4'b1111 for TRIG_COUNT consecutive edges, both builds shall produce identical Q.

Verification
REQ-026 Reset=1 for one edge, then hold W=4'b0000 -> Q=0 after the edge; Q stays 0.
REQ-027 Truth-table sweep, one W per edge, 4'b0000..4'b1111 -> Q one edge later = 0,1,1,0,0,1,1,0,0,1,1,0,1,1,1,1.
REQ-028 TROJAN_EN, TRIG_COUNT=4, W=4'b1111 for 4 edges then W=4'b0001 -> Q=1 through the 4th edge, then Q=0 on the next edge (inverted 1).
REQ-029 TROJAN_EN, W=4'b1111 for 3 edges, 4'b0000 for 1 edge, 4'b1111 for 3 edges, then W=4'b0001 -> never armed; Q=1 after the final edge.
REQ-030 TROJAN_EN armed, then reset=1 for one edge, then W=4'b0001 -> Q=0 on the reset edge and Q=1 on the following edge (disarmed).
REQ-031 Build without the macro, W=4'b1111 for 10 edges, then W=4'b0001 -> Q=1 throughout.
